// File: rtl/ram_port_adapter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_adapter
// Brief    : Adapts a valid/ready byte-addressed request channel to one port
//            of a dual-port RAM. The RAM has a 1-cycle registered read, a
//            word-wide write and no byte enables. Reads come back on a
//            valid/ready response channel. Partial-byte writes are done as
//            read-modify-write.
// Options  : RAM_ADAPTER_BOUNDCHK_EN - when defined, requests whose word
//            index is at or above mem_size never reach the RAM. Such reads
//            return zero data with resp_err_o set. Such writes are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_adapter #(
  parameter int dat_width = 32,
  parameter int adr_width = 32,
  parameter int mem_size  = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [adr_width-1:0]   req_addr_i,
  input  logic [dat_width/8-1:0] req_be_i,
  input  logic [dat_width-1:0]   req_wdata_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [dat_width-1:0]   resp_rdata_o,
  output logic                   resp_err_o,
  output logic [adr_width-1:0]   ram_adr_o,
  output logic                   ram_we_o,
  output logic [dat_width-1:0]   ram_dat_o,
  input  logic [dat_width-1:0]   ram_dat_i
);

  localparam int c_be_w     = dat_width / 8;
  localparam int c_off_bits = $clog2(c_be_w);
  localparam int c_idx_bits = $clog2(mem_size);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_RD_CAP   = 3'd2,
    S_RESP     = 3'd3,
    S_RMW_WAIT = 3'd4,
    S_RMW_CAP  = 3'd5,
    S_RMW_WR   = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 w_accept;
  logic                 w_is_full;
  logic                 w_is_none;
  logic                 w_oob;
  logic                 w_rd_err;
  logic                 w_go_read;
  logic                 w_go_rmw;
  logic                 w_do_full;
  logic [adr_width-1:0] w_word_adr;
  logic [dat_width-1:0] w_merge;
  logic                 w_unused_addr;

  logic [c_be_w-1:0]    r_be;
  logic [dat_width-1:0] r_wdata;

  assign req_ready_o  = (r_state == S_IDLE);
  assign resp_valid_o = (r_state == S_RESP);
  assign w_accept     = req_valid_i & req_ready_o;
  assign w_is_full    = &req_be_i;
  assign w_is_none    = ~|req_be_i;

  // Word index wraps modulo mem_size; byte-lane bits are discarded.
  assign w_word_adr = adr_width'(req_addr_i[c_off_bits +: c_idx_bits]);

  // Low address bits only select a byte lane and are otherwise dropped.
  assign w_unused_addr = ^req_addr_i;

`ifdef RAM_ADAPTER_BOUNDCHK_EN
  logic [adr_width-1:0] w_full_idx;
  logic                 r_rd_err;

  assign w_full_idx = req_addr_i >> c_off_bits;
  assign w_oob      = (w_full_idx >= adr_width'(mem_size));
  assign w_rd_err   = r_rd_err;

  // Remember whether the read in flight was out of range, then publish it
  // alongside the response data; cleared once the response is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_err   <= 1'b0;
      resp_err_o <= 1'b0;
    end else begin
      if (w_go_read) begin
        r_rd_err <= w_oob;
      end
      if (r_state == S_RD_CAP) begin
        resp_err_o <= r_rd_err;
      end else if ((r_state == S_RESP) && resp_ready_i) begin
        resp_err_o <= 1'b0;
      end
    end
  end
`else
  assign w_oob      = 1'b0;
  assign w_rd_err   = 1'b0;
  assign resp_err_o = 1'b0;
`endif

  // Merge latched write bytes over the word just read back from the RAM.
  for (genvar b = 0; b < c_be_w; b++) begin : g_byte
    assign w_merge[b*8 +: 8] = r_be[b] ? r_wdata[b*8 +: 8] : ram_dat_i[b*8 +: 8];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and request classification strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_go_read   = 1'b0;
    w_go_rmw    = 1'b0;
    w_do_full   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!req_we_i) begin
            // Out-of-range reads still walk the read path so the response
            // latency is identical; only the RAM address is left alone.
            w_go_read   = 1'b1;
            w_state_nxt = S_RD_WAIT;
          end else if (!w_oob) begin
            if (w_is_full) begin
              w_do_full = 1'b1;
            end else if (!w_is_none) begin
              w_go_rmw    = 1'b1;
              w_state_nxt = S_RMW_WAIT;
            end
          end
        end
      end
      S_RD_WAIT:  w_state_nxt = S_RD_CAP;
      S_RD_CAP:   w_state_nxt = S_RESP;
      S_RESP: begin
        if (resp_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RMW_WAIT: w_state_nxt = S_RMW_CAP;
      S_RMW_CAP:  w_state_nxt = S_RMW_WR;
      S_RMW_WR:   w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // RAM port controls, RMW capture registers and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_adr_o    <= '0;
      ram_we_o     <= 1'b0;
      ram_dat_o    <= '0;
      resp_rdata_o <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
    end else begin
      ram_we_o <= 1'b0;
      if ((w_go_read && !w_oob) || w_go_rmw || w_do_full) begin
        ram_adr_o <= w_word_adr;
      end
      if (w_do_full) begin
        ram_dat_o <= req_wdata_i;
        ram_we_o  <= 1'b1;
      end
      if (w_go_rmw) begin
        r_be    <= req_be_i;
        r_wdata <= req_wdata_i;
      end
      if (r_state == S_RMW_CAP) begin
        ram_dat_o <= w_merge;
        ram_we_o  <= 1'b1;
      end
      if (r_state == S_RD_CAP) begin
        resp_rdata_o <= w_rd_err ? '0 : ram_dat_i;
      end
    end
  end

endmodule
`default_nettype wire
